// File: rtl/pep_mmacc_splitc_feed_rot_sub.sv
// Rotated-minus-original coefficient feed for the split CMUX path: level-0 permutation,
// negacyclic sign, modular subtraction, then a small output FIFO with early throttle.
module pep_mmacc_splitc_feed_rot_sub #(
  parameter int unsigned HPSI_SET_ID = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PSI         = 8,
  parameter int unsigned R           = 2,
  parameter int unsigned MOD_Q_W     = 5,
  parameter int unsigned MOD_Q       = 17,
  parameter int unsigned N           = 16,
  parameter int unsigned LWE_COEF_W  = 4,
  parameter int unsigned PERM_W      = PSI / 2,
  parameter int unsigned REQ_CMD_W   = 8
) (
  input  logic                                     clk,
  input  logic                                     s_rst_n,
  input  logic [PSI/2-1:0][R-1:0][MOD_Q_W-1:0]     in_data,
  input  logic [PSI/2-1:0][R-1:0][MOD_Q_W-1:0]     in_rot_data,
  input  logic [PERM_W-1:0]                        in_perm_select,
  input  logic [LWE_COEF_W:0]                      in_coef_rot_id0,
  input  logic [REQ_CMD_W-1:0]                     in_rcmd,
  input  logic                                     in_data_avail,
  output logic                                     in_afull,
  output logic [PSI/2-1:0][R-1:0][MOD_Q_W-1:0]     out_data,
  output logic [REQ_CMD_W-1:0]                     out_rcmd,
  output logic                                     out_valid,
  input  logic                                     out_ready
);

  localparam int unsigned HPSI   = PSI / 2;
  localparam int unsigned POS_NB = HPSI * R;
  localparam int unsigned LOG_N  = $clog2(N);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;

  typedef logic [HPSI-1:0][R-1:0][MOD_Q_W-1:0] coef_t;

  coef_t               w_rot_perm;
  coef_t               w_rot_neg;
  coef_t               w_diff;
  logic [POS_NB-1:0]   w_neg_flag;
  logic                w_perm_unused;

  logic                r_s0_avail, r_s1_avail, r_s2_avail;
  coef_t               r_s0_rot, r_s0_data, r_s1_rot, r_s1_data, r_s2_diff;
  logic [POS_NB-1:0]   r_s0_neg;
  logic [REQ_CMD_W-1:0] r_s0_rcmd, r_s1_rcmd, r_s2_rcmd;

  coef_t               r_mem_data [FIFO_DEPTH];
  logic [REQ_CMD_W-1:0] r_mem_rcmd [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                r_out_valid, r_afull;
  logic                w_full, w_push, w_pop;
  logic [OCC_W-1:0]    w_occ_total;

  // Only the select bits belonging to this coefficient set are consumed.
  assign w_perm_unused = ^in_perm_select;

  // Per-position permutation, sign decision, negation and subtraction.
  for (genvar h = 0; h < HPSI; h++) begin : g_h
    localparam int unsigned B = (HPSI_SET_ID * HPSI + h) / 2;
    for (genvar r = 0; r < R; r++) begin : g_r
      localparam int unsigned P = h * R + r;
      assign w_rot_perm[h][r] = in_perm_select[B] ? in_rot_data[h ^ 1][r] : in_rot_data[h][r];
      assign w_neg_flag[P]    = 1'((in_coef_rot_id0 + (LWE_COEF_W+1)'(P)) >> LOG_N);
      assign w_rot_neg[h][r]  = (r_s0_neg[P] && (r_s0_rot[h][r] != '0))
                                ? (MOD_Q_W'(MOD_Q) - r_s0_rot[h][r]) : r_s0_rot[h][r];
      assign w_diff[h][r]     = (r_s1_rot[h][r] < r_s1_data[h][r])
                                ? (r_s1_rot[h][r] - r_s1_data[h][r] + MOD_Q_W'(MOD_Q))
                                : (r_s1_rot[h][r] - r_s1_data[h][r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      r_s0_avail <= 1'b0;
      r_s1_avail <= 1'b0;
      r_s2_avail <= 1'b0;
    end else begin
      r_s0_avail <= in_data_avail;
      r_s1_avail <= r_s0_avail;
      r_s2_avail <= r_s1_avail;
    end
  end

  // Pipeline payload is not reset; validity is carried by the avail chain.
  always_ff @(posedge clk) begin
    r_s0_rot  <= w_rot_perm;
    r_s0_data <= in_data;
    r_s0_neg  <= w_neg_flag;
    r_s0_rcmd <= in_rcmd;
    r_s1_rot  <= w_rot_neg;
    r_s1_data <= r_s0_data;
    r_s1_rcmd <= r_s0_rcmd;
    r_s2_diff <= w_diff;
    r_s2_rcmd <= r_s1_rcmd;
  end

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = r_out_valid && out_ready;
  assign w_push = r_s2_avail && (!w_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  // Throttle counts beats still in the pipeline so they always find room.
  assign w_occ_total = OCC_W'(r_count) + OCC_W'(r_s0_avail) + OCC_W'(r_s1_avail)
                     + OCC_W'(r_s2_avail);

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_afull     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_afull     <= (w_occ_total >= OCC_W'(FIFO_DEPTH - 3));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= r_s2_diff;
      r_mem_rcmd[r_wr_ptr] <= r_s2_rcmd;
    end
  end

  assign out_data  = r_mem_data[r_rd_ptr];
  assign out_rcmd  = r_mem_rcmd[r_rd_ptr];
  assign out_valid = r_out_valid;
  assign in_afull  = r_afull;

  // Upstream ignored the throttle: the beat would be lost.
  a_no_overflow : assert property (@(posedge clk) disable iff (!s_rst_n)
                                   !(r_s2_avail && w_full && !w_pop))
    else $fatal(1, "pep_mmacc_splitc_feed_rot_sub: write into full output fifo");

endmodule

// File: tb/tb_pep_mmacc_splitc_feed_rot_sub.sv
// Scoreboard bench for pep_mmacc_splitc_feed_rot_sub: expected beats are queued when driven
// and compared in order as the FIFO hands them out.
module tb_pep_mmacc_splitc_feed_rot_sub;

  localparam int HPSI = 4;
  localparam int R    = 2;
  localparam int W    = 5;
  localparam int Q    = 17;
  localparam int CW   = 8;
  localparam int FD   = 4;

  typedef logic [HPSI-1:0][R-1:0][W-1:0] coef_t;
  typedef struct {
    coef_t          d;
    logic [CW-1:0]  c;
  } exp_t;

  logic           clk = 1'b0;
  logic           s_rst_n;
  coef_t          in_data, in_rot_data, out_data;
  logic [3:0]     in_perm_select;
  logic [4:0]     in_coef_rot_id0;
  logic [CW-1:0]  in_rcmd, out_rcmd;
  logic           in_data_avail, in_afull, out_valid, out_ready;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pep_mmacc_splitc_feed_rot_sub #(
    .HPSI_SET_ID(0), .FIFO_DEPTH(FD), .PSI(2*HPSI), .R(R), .MOD_Q_W(W), .MOD_Q(Q),
    .N(16), .LWE_COEF_W(4), .PERM_W(4), .REQ_CMD_W(CW)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .in_data(in_data), .in_rot_data(in_rot_data), .in_perm_select(in_perm_select),
    .in_coef_rot_id0(in_coef_rot_id0), .in_rcmd(in_rcmd), .in_data_avail(in_data_avail),
    .in_afull(in_afull), .out_data(out_data), .out_rcmd(out_rcmd),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Reference: permute, sign by rotated index bit 4 (N=16), subtract mod Q.
  function automatic coef_t model(input coef_t d, input coef_t rot, input logic [3:0] perm,
                                  input logic [4:0] id0);
    coef_t o;
    int hs, x, idx, v;
    for (int h = 0; h < HPSI; h++) begin
      for (int r = 0; r < R; r++) begin
        hs  = perm[h/2] ? (h ^ 1) : h;
        x   = int'(rot[hs][r]);
        idx = (int'(id0) + h*R + r) % 32;
        if (idx >= 16 && x != 0) x = Q - x;
        v = x - int'(d[h][r]);
        if (v < 0) v = v + Q;
        o[h][r] = W'(v);
      end
    end
    return o;
  endfunction

  function automatic coef_t const_coef(input int v);
    coef_t o;
    for (int h = 0; h < HPSI; h++)
      for (int r = 0; r < R; r++) o[h][r] = W'(v);
    return o;
  endfunction

  function automatic coef_t rand_coef();
    coef_t o;
    for (int h = 0; h < HPSI; h++)
      for (int r = 0; r < R; r++) o[h][r] = W'($urandom_range(0, Q-1));
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input coef_t d, input coef_t rot, input logic [3:0] perm,
                            input logic [4:0] id0, input logic [CW-1:0] cmd);
    exp_t e;
    in_data         = d;
    in_rot_data     = rot;
    in_perm_select  = perm;
    in_coef_rot_id0 = id0;
    in_rcmd         = cmd;
    in_data_avail   = 1'b1;
    e.d = model(d, rot, perm, id0);
    e.c = cmd;
    sb.push_back(e);
  endtask

  task automatic idle();
    in_data_avail = 1'b0;
  endtask

  task automatic test_reset();
    s_rst_n   = 1'b0;
    out_ready = 1'b1;
    drive_beat(rand_coef(), rand_coef(), 4'hF, 5'd3, 8'hEE);
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (in_afull !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", in_afull); end
    idle();
    sb.delete();
    s_rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_post_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_beat(const_coef(9), const_coef(5), 4'h0, 5'd0, 8'h29);
    tick();
    idle();
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== (k == 3)) begin
        n_err++; $display("FAIL basic_latency: cycle %0d got %b want %b", k, out_valid, (k == 3));
      end
    end
    n_cmp++;
    if (out_data !== const_coef(13)) begin
      n_err++; $display("FAIL basic_data: got %h want %h", out_data, const_coef(13));
    end
    n_cmp++;
    if (out_valid && (out_data !== sb[0].d || out_rcmd !== sb[0].c)) begin
      n_err++; $display("FAIL basic_sb: got %h/%h want %h/%h", out_data, out_rcmd, sb[0].d, sb[0].c);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_negate();
    coef_t rot;
    out_ready = 1'b1;
    rot = const_coef(3);
    rot[0][1] = '0;
    drive_beat(const_coef(0), rot, 4'h0, 5'd15, 8'h30);
    tick();
    rot = rand_coef();
    rot[2][0] = '0;
    drive_beat(rand_coef(), rot, 4'h0, 5'd15, 8'h31);
    tick();
    idle();
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    n_cmp++;
    if (out_data[0][0] !== W'(3) || out_data[0][1] !== W'(0) || out_data[1][0] !== W'(14)
        || out_data[3][1] !== W'(14)) begin
      n_err++; $display("FAIL negate_const: got %h want p0=3 p1=0 p2..=14", out_data);
    end
    for (int c = 0; c < 50 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== sb[0].d || out_rcmd !== sb[0].c) begin
          n_err++; $display("FAIL negate_sb: got %h/%h want %h/%h", out_data, out_rcmd, sb[0].d, sb[0].c);
        end
        void'(sb.pop_front());
      end
      tick();
    end
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL negate_timeout: left %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_perm();
    coef_t rot;
    out_ready = 1'b1;
    for (int h = 0; h < HPSI; h++)
      for (int r = 0; r < R; r++) rot[h][r] = W'(h*R + r + 1);
    drive_beat(const_coef(0), rot, 4'b0001, 5'd0, 8'h41);
    tick();
    drive_beat(rand_coef(), rand_coef(), 4'b0011, 5'(($urandom_range(0, 31))), 8'h42);
    tick();
    idle();
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    n_cmp++;
    if (out_data[0][0] !== W'(3) || out_data[0][1] !== W'(4) || out_data[1][0] !== W'(1)
        || out_data[2][0] !== W'(5) || out_data[3][1] !== W'(8)) begin
      n_err++; $display("FAIL perm_const: got %h want h0<-h1 h1<-h0 rest kept", out_data);
    end
    for (int c = 0; c < 50 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== sb[0].d || out_rcmd !== sb[0].c) begin
          n_err++; $display("FAIL perm_sb: got %h/%h want %h/%h", out_data, out_rcmd, sb[0].d, sb[0].c);
        end
        void'(sb.pop_front());
      end
      tick();
    end
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL perm_timeout: left %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_backpressure();
    bit    afull_seen = 1'b0;
    int    beats_at_afull = -1;
    coef_t held;
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (in_afull && !afull_seen) begin afull_seen = 1'b1; beats_at_afull = sb.size(); end
      if (!in_afull) drive_beat(rand_coef(), rand_coef(), 4'($urandom_range(0, 15)),
                                5'($urandom_range(0, 31)), 8'(8'h50 + c));
      else idle();
      tick();
    end
    idle();
    n_cmp++;
    if (!afull_seen || beats_at_afull >= FD) begin
      n_err++; $display("FAIL bp_afull: seen %b beats %0d want seen before %0d", afull_seen, beats_at_afull, FD);
    end
    n_cmp++;
    if (sb.size() > FD || sb.size() == 0) begin
      n_err++; $display("FAIL bp_count: got %0d beats want 1..%0d", sb.size(), FD);
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    held = out_data;
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== held) begin
      n_err++; $display("FAIL bp_hold: got %b/%h want 1/%h", out_valid, out_data, held);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== sb[0].d || out_rcmd !== sb[0].c) begin
          n_err++; $display("FAIL bp_sb: got %h/%h want %h/%h", out_data, out_rcmd, sb[0].d, sb[0].c);
        end
        void'(sb.pop_front());
      end
      tick();
    end
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL bp_timeout: left %0d want 0", sb.size()); sb.delete(); end
    repeat (2) tick();
    n_cmp++;
    if (in_afull !== 1'b0) begin n_err++; $display("FAIL bp_afull_clear: got %b want 0", in_afull); end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < FD - 1; i++) begin
      drive_beat(rand_coef(), rand_coef(), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 8'(i));
      tick();
    end
    idle();
    repeat (5) tick();
    // Pops start exactly when the first streamed beat lands, holding occupancy at FD-1.
    for (int i = 0; i < 103; i++) begin
      if (i >= 3) out_ready = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL pp_valid: cycle %0d got %b want 1", i, out_valid); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== sb[0].d || out_rcmd !== sb[0].c) begin
          n_err++; $display("FAIL pp_sb: got %h/%h want %h/%h", out_data, out_rcmd, sb[0].d, sb[0].c);
        end
        void'(sb.pop_front());
      end
      if (i < 100) drive_beat(rand_coef(), rand_coef(), 4'($urandom_range(0, 15)),
                              5'($urandom_range(0, 31)), 8'(8'h80 + i));
      else idle();
      tick();
    end
    idle();
    for (int c = 0; c < 50 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== sb[0].d || out_rcmd !== sb[0].c) begin
          n_err++; $display("FAIL pp_drain: got %h/%h want %h/%h", out_data, out_rcmd, sb[0].d, sb[0].c);
        end
        void'(sb.pop_front());
      end
      tick();
    end
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL pp_timeout: left %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(rand_coef(), rand_coef(), 4'h0, 5'd0, 8'(8'hA0 + i));
      tick();
    end
    idle();
    repeat (5) tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid: got %b want 1", out_valid); end
    s_rst_n = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_afull !== 1'b0) begin
      n_err++; $display("FAIL rm_flush: got valid %b afull %b want 0 0", out_valid, in_afull);
    end
    s_rst_n = 1'b1;
    sb.delete();
    out_ready = 1'b1;
    drive_beat(rand_coef(), rand_coef(), 4'b0010, 5'd12, 8'hB7);
    tick();
    idle();
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== (k == 3)) begin
        n_err++; $display("FAIL rm_latency: cycle %0d got %b want %b", k, out_valid, (k == 3));
      end
    end
    n_cmp++;
    if (out_data !== sb[0].d || out_rcmd !== sb[0].c) begin
      n_err++; $display("FAIL rm_sb: got %h/%h want %h/%h", out_data, out_rcmd, sb[0].d, sb[0].c);
    end
    sb.delete();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_empty: got %b want 0", out_valid); end
  endtask

  initial begin
    s_rst_n = 1'b0;
    in_data = '0;
    in_rot_data = '0;
    in_perm_select = '0;
    in_coef_rot_id0 = '0;
    in_rcmd = '0;
    in_data_avail = 1'b0;
    out_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_negate();
    test_perm();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

endmodule
